// File: rtl/cut_bist_driver.sv
// BIST driver: LFSR stimulus into the CUT, MISR compaction of its outputs, start/busy/done sequencing.
// Latency: done rises 1+N*(S+2) cycles after the start edge; abort returns to IDLE in one cycle.
module cut_bist_driver #(
    parameter int             IN_W  = 15,
    parameter int             OUT_W = 11,
    parameter int             CNT_W = 16,
    parameter logic [IN_W-1:0] SEED = 15'h0001
) (
    input  logic             blif_clk_net,
    input  logic             blif_reset_net,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [3:0]       settle_cycles,
    output logic [IN_W-1:0]  cut_in,
    input  logic [OUT_W-1:0] cut_out,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] signature,
    output logic [CNT_W-1:0] pattern_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_APPLY,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           state;
    logic [IN_W-1:0]  lfsr;
    logic [OUT_W-1:0] misr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_lat;
    logic [3:0]       s_lat;
    logic [3:0]       settle_cnt;
    logic             busy_r;
    logic             done_r;

    logic [CNT_W-1:0] cnt_nxt;
    logic [IN_W-1:0]  lfsr_nxt;
    logic [OUT_W-1:0] misr_nxt;

    always_comb begin
        cnt_nxt  = cnt + CNT_W'(1);
        lfsr_nxt = {lfsr[IN_W-2:0], lfsr[IN_W-1] ^ lfsr[IN_W-2]};
        misr_nxt = {misr[OUT_W-2:0], misr[OUT_W-1] ^ misr[OUT_W-3]} ^ cut_out;
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state      <= S_IDLE;
            lfsr       <= SEED;
            misr       <= '0;
            cnt        <= '0;
            n_lat      <= '0;
            s_lat      <= '0;
            settle_cnt <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // abort outranks a coincident start
                    if (abort) begin
                        state  <= S_IDLE;
                        done_r <= 1'b0;
                    end else if (start) begin
                        state  <= S_LOAD;
                        busy_r <= 1'b1;
                        done_r <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        lfsr       <= SEED;
                        misr       <= '0;
                        cnt        <= '0;
                        n_lat      <= num_patterns;
                        s_lat      <= settle_cycles;
                        settle_cnt <= '0;
                        if (num_patterns == '0) begin
                            state  <= S_DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end else begin
                            state <= S_APPLY;
                        end
                    end
                end
                S_APPLY: begin
                    if (abort) begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end else if (settle_cnt == s_lat) begin
                        state      <= S_CAPTURE;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                S_CAPTURE: begin
                    if (abort) begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        misr <= misr_nxt;
                        lfsr <= lfsr_nxt;
                        cnt  <= cnt_nxt;
                        if (cnt_nxt == n_lat) begin
                            state  <= S_DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end else begin
                            state <= S_APPLY;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign cut_in        = lfsr;
    assign signature     = misr;
    assign pattern_count = cnt;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_cut_bist_driver.sv
// Randomized scoreboard bench for cut_bist_driver: a timeline model predicts each run's outcome.
module tb_cut_bist_driver;

    localparam logic [14:0] SEED = 15'h0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] num_patterns = '0;
    logic [3:0]  settle_cycles = '0;
    logic [14:0] cut_in;
    logic [10:0] cut_out = '0;
    logic        busy;
    logic        done;
    logic [10:0] signature;
    logic [15:0] pattern_count;

    cut_bist_driver dut (
        .blif_clk_net   (clk),
        .blif_reset_net (rst_n),
        .start          (start),
        .abort          (abort),
        .num_patterns   (num_patterns),
        .settle_cycles  (settle_cycles),
        .cut_in         (cut_in),
        .cut_out        (cut_out),
        .busy           (busy),
        .done           (done),
        .signature      (signature),
        .pattern_count  (pattern_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [10:0] sig;
        logic [15:0] cnt;
        logic [14:0] lfsr;
        logic        dn;
        int          e_start;
        int          e_end;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] m_misr = '0;
    logic [14:0] m_lfsr = SEED;
    logic [15:0] m_cnt  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Polynomial steps written as plain shift/mask arithmetic.
    function automatic logic [10:0] misr_step(input logic [10:0] m, input logic [10:0] co);
        int v;
        v = ((int'(m) << 1) & 'h7FF) | (((int'(m) >> 10) ^ (int'(m) >> 8)) & 1);
        return 11'(v) ^ co;
    endfunction

    function automatic logic [14:0] lfsr_step(input logic [14:0] l);
        int v;
        v = ((int'(l) << 1) & 'h7FFF) | (((int'(l) >> 14) ^ (int'(l) >> 13)) & 1);
        return 15'(v);
    endfunction

    // One run: start at edge e; captures fall on edges e+1+k*(s+2), k=1..n.
    task automatic do_run(input int n, input int s, input int abort_off, input int fixed_co);
        int  e;
        int  end_e;
        bit  ab;
        exp_t it;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b0;
        num_patterns = 16'(n);
        settle_cycles = 4'(s);
        cut_out = (fixed_co >= 0) ? 11'(fixed_co) : 11'($urandom);
        e = cyc + 1;
        end_e = e + 1 + n * (s + 2);
        ab = 1'b0;
        if (abort_off > 0 && e + abort_off < end_e) begin
            end_e = e + abort_off;
            ab = 1'b1;
        end
        for (int t = e + 1; t <= end_e; t++) begin
            @(negedge clk);
            start = (t > e + 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
            if (t > e + 1) begin
                num_patterns = 16'($urandom);
                settle_cycles = 4'($urandom);
            end
            cut_out = (fixed_co >= 0) ? 11'(fixed_co) : 11'($urandom);
            abort = ab && (t == end_e);
            if (!(ab && t == end_e)) begin
                if (t == e + 1) begin
                    m_misr = '0;
                    m_lfsr = SEED;
                    m_cnt  = '0;
                end else if ((t - e - 1) % (s + 2) == 0) begin
                    m_misr = misr_step(m_misr, cut_out);
                    m_lfsr = lfsr_step(m_lfsr);
                    m_cnt  = m_cnt + 16'd1;
                end
            end
            if (t == end_e) begin
                it.sig = m_misr;
                it.cnt = m_cnt;
                it.lfsr = m_lfsr;
                it.dn = !ab;
                it.e_start = e;
                it.e_end = end_e;
                q.push_back(it);
            end
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Monitor: each busy fall closes one run and is scored against the queue head.
    initial begin
        int   rise;
        bit   pb;
        exp_t it;
        rise = -1;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pb = 1'b0;
                continue;
            end
            if (!pb && busy) rise = cyc;
            if (pb && !busy) begin
                if (q.size() == 0) begin
                    check("unexpected_busy_fall", 32'd0, 32'd1);
                end else begin
                    it = q.pop_front();
                    check("busy_rise_edge", rise, it.e_start);
                    check("busy_fall_edge", cyc, it.e_end);
                    check("done", 32'(done), 32'(it.dn));
                    check("signature", 32'(signature), 32'(it.sig));
                    check("pattern_count", 32'(pattern_count), 32'(it.cnt));
                    check("cut_in", 32'(cut_in), 32'(it.lfsr));
                end
            end
            pb = busy;
        end
    end

    initial begin
        int n;
        int s;
        int ab;
        repeat (3) @(negedge clk);
        check("rst_cut_in", 32'(cut_in), 32'(SEED));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_signature", 32'(signature), 32'd0);
        check("rst_count", 32'(pattern_count), 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of APPLY, after one capture has landed.
        @(negedge clk);
        start = 1'b1;
        num_patterns = 16'd3;
        settle_cycles = 4'd0;
        cut_out = 11'h7FF;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_signature", 32'(signature), 32'h7FF);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_done", 32'(done), 32'd0);
        check("midrun_rst_signature", 32'(signature), 32'd0);
        check("midrun_rst_cut_in", 32'(cut_in), 32'(SEED));
        m_misr = '0;
        m_lfsr = SEED;
        m_cnt  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cut_out = '0;

        do_run(1, 0, 0, 'h555);
        check("n1_signature", 32'(signature), 32'h555);
        do_run(2, 0, 0, 'h555);
        check("n2_signature", 32'(signature), 32'h7FF);
        do_run(14, 3, 0, 0);
        check("n14_cut_in", 32'(cut_in), 32'h4001);
        do_run(0, 2, 0, -1);
        check("n0_done", 32'(done), 32'd1);

        // start together with abort in DONE: abort wins.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'd0);
        check("start_abort_done", 32'(done), 32'd0);

        do_run(5, 1, 8, -1);
        check("abort_count", 32'(pattern_count), 32'd2);
        do_run(1, 0, 0, 'h123);

        for (int r = 0; r < 30; r++) begin
            n = $urandom_range(0, 8);
            s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 1 + n * (s + 2)) : 0;
            do_run(n, s, ab, -1);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                cut_out = 11'($urandom);
            end
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
